ball_controller: RTL and testbench
==================================

# ball_controller

Ball motion engine for the Pong datapath, directly downstream of the collision/score logic. Consumes its 2-bit `bounce` event code once per movement tick, and owns the ball's position, direction, speed and serve delay. Drives `ball_pos_x/y` and `ball_size_x/y` back to the collision logic and to the renderer.

## Interface

**Parameters**
- `SCREEN_X`, 640: screen width in pixels.
- `SCREEN_Y`, 480: screen height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels, square ball.
- `SPEED`, 2: pixels moved per tick on each axis after a serve.
- `MAX_SPEED`, 6: speed ceiling; used only with speed-up enabled.
- `SERVE_TICKS`, 60: ticks the ball holds at centre before moving.
- `LOCKOUT_TICKS`, 4: ticks after a flip during which bounce codes 1/2 are ignored.

**Ports**
- `clock` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: one-cycle movement strobe (frame rate). Consecutive strobes are ≥2 cycles apart.
- `bounce` input 2: event code. 0 = none, 1 = paddle, 2 = wall, 3 = score.
- `ball_pos_x` output 10: left edge of the ball.
- `ball_pos_y` output 10: top edge of the ball.
- `ball_size_x` output 8: constant `BALL_SIZE`.
- `ball_size_y` output 8: constant `BALL_SIZE`.
- `serving` output 1: high while in SERVE.
- `dir_x` output 1: 1 = moving right.
- `dir_y` output 1: 1 = moving down.

## Operation

**Reset values**
- `ball_pos_x` = (SCREEN_X−BALL_SIZE)/2 = 316; `ball_pos_y` = (SCREEN_Y−BALL_SIZE)/2 = 236.
- `dir_x` = 1, `dir_y` = 1.
- State SERVE; `serving` = 1.
- Serve counter = SERVE_TICKS; lockout counter = 0; speed = SPEED.

**States**
- SERVE: position held at centre.
  - Each tick decrements the serve counter.
  - On the tick where the counter is 1 → MOVE, with counter reload to SERVE_TICKS.
  - `bounce` is ignored in SERVE.
- MOVE: on each tick, evaluate `bounce` with the priority below, then step.
  - Code 3: → SERVE. Position reset to centre; speed reset to SPEED; lockout cleared.
    - `dir_x` is kept, so the serve goes toward the side that conceded. `dir_y` is kept.
    - No step is taken on this tick.
  - Code 1 with lockout = 0: toggle `dir_x`; load lockout = LOCKOUT_TICKS.
  - Code 2 with lockout = 0: toggle `dir_y`; load lockout = LOCKOUT_TICKS.
  - Code 1 or 2 with lockout ≠ 0: ignored; lockout decrements.
  - Code 0: lockout decrements if nonzero.
  - Step: each axis moves by `speed` in its new direction, i.e. a flip takes effect on the same tick.

**Arithmetic**
- Positions are 10-bit unsigned; subtraction saturates at 0.
- Addition saturates at SCREEN_X−BALL_SIZE (x) and SCREEN_Y−BALL_SIZE (y).
- The clamp never wraps.
- Speed is 3-bit; MAX_SPEED ≤ 7.

**Boundary cases**
- Reset mid-MOVE or mid-SERVE returns all state to reset values immediately.
- `tick` and `reset` asserted in the same cycle: reset wins.
- Non-tick cycles: no state change, regardless of `bounce`.

## Timing

- `bounce` is sampled only in `tick` cycles.
- The collision logic registers `bounce` one cycle after the position changes; the ≥2-cycle tick spacing guarantees that the sampled code reflects the current position.
- Outputs are registered and update on the clock edge that samples `tick` (1-cycle latency from tick to new position).
- `serving` falls on the same edge as the first move transition. The first movement step occurs on the next tick.

## Configuration

- `BALL_SPEEDUP_EN` defined:
  - Every accepted paddle bounce (code 1, lockout 0) increments speed, saturating at MAX_SPEED.
  - The new speed applies to the step on that same tick.
  - Speed resets to SPEED on a score or reset.
- `BALL_SPEEDUP_EN` undefined: speed is constant SPEED; MAX_SPEED is unused.

## Structure

- Shared package `pong_pkg`:
  - Screen constants.
  - Bounce code constants: BOUNCE_NONE, BOUNCE_PADDLE, BOUNCE_WALL, BOUNCE_SCORE.
  - State enum: SERVE, MOVE.
- Sub-module `ball_axis`: per-axis stepper (position register, direction bit, saturating add/subtract, flip input). Instantiated once for x and once for y.
- The top level holds the FSM, serve counter, lockout counter and speed register.

## Test plan

- Reset, then 60 ticks with `bounce` = 0:
  - Position stays (316,236) and `serving` = 1 for ticks 1–59.
  - Tick 60 clears `serving`.
  - Tick 61 gives position (318,238).
- In MOVE heading right, `bounce` = 1 on a tick:
  - `dir_x` becomes 0 and x decreases by 2 that tick.
  - `bounce` = 1 held for the next 4 ticks causes no further toggle.
  - The 5th tick with `bounce` = 1 toggles again.
- `bounce` = 2 at y = 1 moving up: `dir_y` = 1 and y = 3.
  - Separately, a step from x = 1 moving left with speed 2 clamps x to 0.
- `bounce` = 3 mid-lockout while moving right:
  - → SERVE, position (316,236), `dir_x` = 1, lockout cleared.
  - Serve delay restarts at 60 ticks.
- Assert `reset` asynchronously between ticks during MOVE: outputs return to reset values before the next clock edge.
- With `BALL_SPEEDUP_EN`: 6 accepted paddle bounces give step sizes 3, 4, 5, 6, 6, 6; after a score the step is 2 again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong datapath definitions: screen geometry, bounce event codes and
// the ball FSM state type.
package pong_pkg;

  localparam int unsigned SCREEN_X_DEFAULT = 640;
  localparam int unsigned SCREEN_Y_DEFAULT = 480;
  localparam int unsigned POS_W            = 10;
  localparam int unsigned SIZE_W           = 8;
  localparam int unsigned SPEED_W          = 3;

  localparam logic [1:0] BOUNCE_NONE   = 2'd0;
  localparam logic [1:0] BOUNCE_PADDLE = 2'd1;
  localparam logic [1:0] BOUNCE_WALL   = 2'd2;
  localparam logic [1:0] BOUNCE_SCORE  = 2'd3;

  typedef enum logic {
    SERVE = 1'b0,
    MOVE  = 1'b1
  } ball_state_t;

  // Left/top edge that centres an object of the given size on a screen axis.
  function automatic int unsigned centre_pos(input int unsigned screen,
                                             input int unsigned size);
    return (screen - size) / 2;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// Per-axis ball stepper: holds one coordinate and its direction, applies an
// optional direction flip and a saturating step of `speed` pixels.
module ball_axis
  import pong_pkg::*;
#(
  parameter int unsigned AXIS_W  = 10,
  parameter int unsigned STEP_W  = 3,
  parameter int unsigned LIMIT   = 632,
  parameter int unsigned INIT    = 316
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_en,
  input  logic              flip,
  input  logic              recentre,
  input  logic [STEP_W-1:0] speed,
  output logic [AXIS_W-1:0] pos,
  output logic              dir
);

  localparam int unsigned SUM_W = AXIS_W + 1;

  logic              dir_next;
  logic [SUM_W-1:0]  sum;
  logic [AXIS_W-1:0] pos_next;

  // Saturating step in the post-flip direction; never wraps past 0 or LIMIT.
  always_comb begin
    dir_next = dir ^ flip;
    sum      = {1'b0, pos} + SUM_W'(speed);
    pos_next = pos;
    if (dir_next) begin
      pos_next = (sum > SUM_W'(LIMIT)) ? AXIS_W'(LIMIT) : sum[AXIS_W-1:0];
    end else begin
      pos_next = (pos < AXIS_W'(speed)) ? '0 : pos - AXIS_W'(speed);
    end
  end

  // Position/direction register; recentre keeps the direction untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= AXIS_W'(INIT);
      dir <= 1'b1;
    end else if (recentre) begin
      pos <= AXIS_W'(INIT);
    end else if (step_en) begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Ball motion engine: serve delay, bounce handling with lockout, and per-tick
// stepping of the ball via two ball_axis instances.
// Optional feature macro: BALL_SPEEDUP_EN (each accepted paddle bounce
// increments speed up to MAX_SPEED).
module ball_controller
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_X      = SCREEN_X_DEFAULT,
  parameter int unsigned SCREEN_Y      = SCREEN_Y_DEFAULT,
  parameter int unsigned BALL_SIZE     = 8,
  parameter int unsigned SPEED         = 2,
  parameter int unsigned MAX_SPEED     = 6,
  parameter int unsigned SERVE_TICKS   = 60,
  parameter int unsigned LOCKOUT_TICKS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic [1:0]        bounce,
  output logic [POS_W-1:0]  ball_pos_x,
  output logic [POS_W-1:0]  ball_pos_y,
  output logic [SIZE_W-1:0] ball_size_x,
  output logic [SIZE_W-1:0] ball_size_y,
  output logic              serving,
  output logic              dir_x,
  output logic              dir_y
);

  localparam int unsigned X_MAX    = SCREEN_X - BALL_SIZE;
  localparam int unsigned Y_MAX    = SCREEN_Y - BALL_SIZE;
  localparam int unsigned X_CENTRE = centre_pos(SCREEN_X, BALL_SIZE);
  localparam int unsigned Y_CENTRE = centre_pos(SCREEN_Y, BALL_SIZE);
  localparam int unsigned SERVE_W  = $clog2(SERVE_TICKS + 1);
  localparam int unsigned LOCK_W   = $clog2(LOCKOUT_TICKS + 1);
  localparam int unsigned SPEED_MAX_REPR = (1 << SPEED_W) - 1;

  // Reject configurations the 3-bit speed and counters cannot represent.
  if (MAX_SPEED > SPEED_MAX_REPR || SPEED > MAX_SPEED || SPEED == 0 ||
      SERVE_TICKS == 0 || LOCKOUT_TICKS == 0) begin : g_bad_params
    $error("ball_controller: unsupported parameter combination");
  end

  ball_state_t        state, state_next;
  logic [SERVE_W-1:0] serve_cnt, serve_cnt_next;
  logic [LOCK_W-1:0]  lock_cnt, lock_cnt_next;
  logic [SPEED_W-1:0] speed, speed_next;
  logic               flip_x, flip_y, step_en, recentre;

  // Next-state logic: serve countdown, bounce priority and lockout handling.
  always_comb begin
    state_next     = state;
    serve_cnt_next = serve_cnt;
    lock_cnt_next  = lock_cnt;
    speed_next     = speed;
    flip_x         = 1'b0;
    flip_y         = 1'b0;
    step_en        = 1'b0;
    recentre       = 1'b0;
    if (tick) begin
      if (state == SERVE) begin
        if (serve_cnt <= SERVE_W'(1)) begin
          state_next     = MOVE;
          serve_cnt_next = SERVE_W'(SERVE_TICKS);
        end else begin
          serve_cnt_next = serve_cnt - SERVE_W'(1);
        end
      end else if (bounce == BOUNCE_SCORE) begin
        // Score: back to centre; directions kept so the serve heads to the loser.
        state_next     = SERVE;
        recentre       = 1'b1;
        speed_next     = SPEED_W'(SPEED);
        lock_cnt_next  = '0;
        serve_cnt_next = SERVE_W'(SERVE_TICKS);
      end else begin
        step_en = 1'b1;
        if (lock_cnt == '0 && bounce == BOUNCE_PADDLE) begin
          flip_x        = 1'b1;
          lock_cnt_next = LOCK_W'(LOCKOUT_TICKS);
`ifdef BALL_SPEEDUP_EN
          if (speed < SPEED_W'(MAX_SPEED)) begin
            speed_next = speed + SPEED_W'(1);
          end
`endif
        end else if (lock_cnt == '0 && bounce == BOUNCE_WALL) begin
          flip_y        = 1'b1;
          lock_cnt_next = LOCK_W'(LOCKOUT_TICKS);
        end else if (lock_cnt != '0) begin
          lock_cnt_next = lock_cnt - LOCK_W'(1);
        end
      end
    end
  end

  // FSM, counters and speed registers; serving is registered off next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SERVE;
      serving   <= 1'b1;
      serve_cnt <= SERVE_W'(SERVE_TICKS);
      lock_cnt  <= '0;
      speed     <= SPEED_W'(SPEED);
    end else begin
      state     <= state_next;
      serving   <= (state_next == SERVE);
      serve_cnt <= serve_cnt_next;
      lock_cnt  <= lock_cnt_next;
      speed     <= speed_next;
    end
  end

  assign ball_size_x = SIZE_W'(BALL_SIZE);
  assign ball_size_y = SIZE_W'(BALL_SIZE);

  ball_axis #(
    .AXIS_W (POS_W),
    .STEP_W (SPEED_W),
    .LIMIT  (X_MAX),
    .INIT   (X_CENTRE)
  ) u_axis_x (
    .clock    (clock),
    .reset    (reset),
    .step_en  (step_en),
    .flip     (flip_x),
    .recentre (recentre),
    .speed    (speed_next),
    .pos      (ball_pos_x),
    .dir      (dir_x)
  );

  ball_axis #(
    .AXIS_W (POS_W),
    .STEP_W (SPEED_W),
    .LIMIT  (Y_MAX),
    .INIT   (Y_CENTRE)
  ) u_axis_y (
    .clock    (clock),
    .reset    (reset),
    .step_en  (step_en),
    .flip     (flip_y),
    .recentre (recentre),
    .speed    (speed_next),
    .pos      (ball_pos_y),
    .dir      (dir_y)
  );

endmodule

// File: tb/tb_ball_controller.sv
// Scoreboard bench for ball_controller: a behavioural model predicts the ball
// state after every tick; a monitor compares on each update and checks that
// outputs hold steady between ticks.
module tb_ball_controller;

  localparam int SCREEN_X      = 640;
  localparam int SCREEN_Y      = 480;
  localparam int BALL_SIZE     = 8;
  localparam int SPEED         = 2;
  localparam int MAX_SPEED     = 6;
  localparam int SERVE_TICKS   = 60;
  localparam int LOCKOUT_TICKS = 4;
  localparam int X_MAX         = SCREEN_X - BALL_SIZE;
  localparam int Y_MAX         = SCREEN_Y - BALL_SIZE;
  localparam int CX            = 316;
  localparam int CY            = 236;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] bounce;
  logic [9:0] ball_pos_x, ball_pos_y;
  logic [7:0] ball_size_x, ball_size_y;
  logic       serving, dir_x, dir_y;

  ball_controller dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .bounce      (bounce),
    .ball_pos_x  (ball_pos_x),
    .ball_pos_y  (ball_pos_y),
    .ball_size_x (ball_size_x),
    .ball_size_y (ball_size_y),
    .serving     (serving),
    .dir_x       (dir_x),
    .dir_y       (dir_y)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
    logic       srv;
  } obs_t;

  obs_t exp_q[$];
  obs_t cur_exp;
  bit   have_exp = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic tick_d = 1'b0;

  // Behavioural model state.
  int m_serving, m_x, m_y, m_dx, m_dy, m_serve_left, m_lock, m_speed;

  function automatic obs_t observed();
    obs_t o;
    o.x = ball_pos_x; o.y = ball_pos_y; o.dx = dir_x; o.dy = dir_y; o.srv = serving;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.x = 10'(CX); o.y = 10'(CY); o.dx = 1'b1; o.dy = 1'b1; o.srv = 1'b1;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.x = 10'(m_x); o.y = 10'(m_y); o.dx = 1'(m_dx); o.dy = 1'(m_dy); o.srv = 1'(m_serving);
    return o;
  endfunction

  function automatic void model_reset();
    m_serving = 1; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
    m_serve_left = SERVE_TICKS; m_lock = 0; m_speed = SPEED;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One movement tick of the ball, straight from the game rules.
  function automatic void model_tick(input int b);
    if (m_serving != 0) begin
      m_serve_left = m_serve_left - 1;
      if (m_serve_left == 0) begin
        m_serving = 0;
        m_serve_left = SERVE_TICKS;
      end
      return;
    end
    if (b == 3) begin
      m_serving = 1; m_x = CX; m_y = CY; m_speed = SPEED; m_lock = 0;
      m_serve_left = SERVE_TICKS;
      return;
    end
    if (m_lock == 0 && (b == 1 || b == 2)) begin
      if (b == 1) begin
        m_dx = 1 - m_dx;
`ifdef BALL_SPEEDUP_EN
        if (m_speed < MAX_SPEED) m_speed = m_speed + 1;
`endif
      end else begin
        m_dy = 1 - m_dy;
      end
      m_lock = LOCKOUT_TICKS;
    end else if (m_lock > 0) begin
      m_lock = m_lock - 1;
    end
    m_x = clampi(m_dx != 0 ? m_x + m_speed : m_x - m_speed, X_MAX);
    m_y = clampi(m_dy != 0 ? m_y + m_speed : m_y - m_speed, Y_MAX);
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got x=%0d y=%0d dx=%0b dy=%0b serving=%0b, want x=%0d y=%0d dx=%0b dy=%0b serving=%0b",
               name, $time, got.x, got.y, got.dx, got.dy, got.srv,
               want.x, want.y, want.dx, want.dy, want.srv);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // Marks the cycle after a tick was accepted, i.e. when outputs carry its result.
  always @(posedge clock) tick_d <= tick && !reset;

  // Monitor: compare each update against the scoreboard and idle cycles against the last state.
  always @(negedge clock) begin
    if (!reset) begin
      if (tick_d) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update @%0t: got x=%0d y=%0d, want no update",
                   $time, ball_pos_x, ball_pos_y);
        end else begin
          cur_exp = exp_q.pop_front();
          have_exp = 1'b1;
          check_obs("tick_update", observed(), cur_exp);
        end
      end else if (have_exp) begin
        check_obs("idle_hold", observed(), cur_exp);
      end
    end
  end

  task automatic do_tick(input int b);
    @(negedge clock);
    tick = 1'b1;
    bounce = 2'(b);
    model_tick(b);
    exp_q.push_back(model_obs());
    @(negedge clock);
    tick = 1'b0;
    bounce = 2'($urandom_range(0, 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bounce = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_obs("async_reset", observed(), reset_obs());
    model_reset();
    cur_exp = model_obs();
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic tick_with_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    tick = 1'b1;
    bounce = 2'd1;
    model_reset();
    cur_exp = model_obs();
    @(negedge clock);
    tick = 1'b0;
    check_obs("tick_with_reset", observed(), reset_obs());
    #1 reset = 1'b0;
  endtask

  function automatic int rand_bounce();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 75) return 0;
    if (r < 86) return 1;
    if (r < 97) return 2;
    return 3;
  endfunction

  int step_exp[6];
  int prev_x, delta;

  initial begin
`ifdef BALL_SPEEDUP_EN
    step_exp = '{3, 4, 5, 6, 6, 6};
`else
    step_exp = '{2, 2, 2, 2, 2, 2};
`endif
    reset = 1'b1; tick = 1'b0; bounce = 2'd0;
    model_reset();
    cur_exp = model_obs();
    have_exp = 1'b1;
    repeat (3) @(negedge clock);
    check_obs("reset_state", observed(), reset_obs());
    check_val("ball_size_x", int'(ball_size_x), BALL_SIZE);
    check_val("ball_size_y", int'(ball_size_y), BALL_SIZE);
    #1 reset = 1'b0;

    // Serve delay: 59 held ticks, 60th leaves serve, 61st is the first step.
    repeat (59) do_tick(0);
    check_val("serving_after_59", int'(serving), 1);
    do_tick(0);
    check_val("serving_after_60", int'(serving), 0);
    check_val("x_after_60", int'(ball_pos_x), CX);
    do_tick(0);
    check_val("x_after_61", int'(ball_pos_x), 318);
    check_val("y_after_61", int'(ball_pos_y), 238);

    // Paddle bounce, lockout for 4 ticks, then a second toggle.
    do_tick(1);
    check_val("dir_x_first_paddle", int'(dir_x), 0);
    check_val("x_first_paddle", int'(ball_pos_x), 318 - step_exp[0]);
    for (int i = 0; i < 4; i++) begin
      do_tick(1);
      check_val("dir_x_locked", int'(dir_x), 0);
    end
    do_tick(1);
    check_val("dir_x_second_paddle", int'(dir_x), 1);

    // Score in the middle of a lockout while moving right.
    do_tick(0);
    do_tick(3);
    check_val("score_serving", int'(serving), 1);
    check_val("score_x", int'(ball_pos_x), CX);
    check_val("score_y", int'(ball_pos_y), CY);
    check_val("score_dir_x", int'(dir_x), 1);
    repeat (59) do_tick(0);
    check_val("reserve_59", int'(serving), 1);
    do_tick(0);
    check_val("reserve_60", int'(serving), 0);

    // Step sizes over six accepted paddle bounces, then after a score.
    for (int k = 0; k < 6; k++) begin
      prev_x = int'(ball_pos_x);
      do_tick(1);
      delta = int'(ball_pos_x) - prev_x;
      if (delta < 0) delta = -delta;
      check_val("paddle_step", delta, step_exp[k]);
      repeat (LOCKOUT_TICKS) do_tick(0);
    end
    do_tick(3);
    repeat (SERVE_TICKS) do_tick(0);
    prev_x = int'(ball_pos_x);
    do_tick(0);
    delta = int'(ball_pos_x) - prev_x;
    if (delta < 0) delta = -delta;
    check_val("step_after_score", delta, SPEED);

    // Long run without bounces drives both axes into the clamps.
    for (int i = 0; i < 350; i++) begin
      do_tick(0);
      idle(int'($urandom_range(0, 1)));
    end
    check_val("y_clamped", int'(ball_pos_y), (m_dy != 0) ? Y_MAX : 0);
    check_val("x_clamped", int'(ball_pos_x), (m_dx != 0) ? X_MAX : 0);
    async_reset();
    tick_with_reset();

    // Randomised play with resets sprinkled in.
    for (int i = 0; i < 1200; i++) begin
      do_tick(rand_bounce());
      idle(int'($urandom_range(0, 2)));
      if (i == 400) async_reset();
      if (i == 800) tick_with_reset();
    end

    repeat (3) @(negedge clock);
    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
